// File: rtl/rv_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_mdu_pkg
// Description : Shared types and decode helpers for the RV32M multiply/divide
//               unit: funct3 operation encodings, FSM state type and the
//               operand-signedness / divide-class decode functions.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_mdu_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    // Divide-class operation (DIV/DIVU/REM/REMU)
    function automatic logic is_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // Remainder-returning operation (REM/REMU)
    function automatic logic is_rem(input mdu_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // rs1 interpreted as two's complement. MUL only needs the low half of the
    // product, which is identical for signed and unsigned operands.
    function automatic logic is_signed_a(input mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 interpreted as two's complement
    function automatic logic is_signed_b(input mdu_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_step
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply mode: one shift-add step on {hi, lo} where lo holds
//               the remaining multiplier bits and hi the partial product.
//               Divide mode: one restoring-division step on {rem, quo} where
//               quo shifts the dividend out and the quotient bits in.
// Ports       : i_div     - 1 selects restoring divide, 0 selects shift-add
//               i_acc     - 2*XLEN accumulator before this step
//               i_operand - multiplicand magnitude or divisor magnitude
//               o_acc     - 2*XLEN accumulator after this step
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_step #(
    parameter int XLEN = 32
) (
    input  logic                i_div,
    input  logic [2*XLEN-1:0]   i_acc,
    input  logic [XLEN-1:0]     i_operand,
    output logic [2*XLEN-1:0]   o_acc
);

    logic [XLEN:0] w_sum;      // partial product + multiplicand, with carry
    logic [XLEN:0] w_shifted;  // partial remainder after shifting in next dividend bit
    logic [XLEN:0] w_diff;     // trial subtraction; MSB set means "restore"

    always_comb begin
        w_sum     = {1'b0, i_acc[2*XLEN-1:XLEN]}
                  + (i_acc[0] ? {1'b0, i_operand} : {(XLEN+1){1'b0}});
        w_shifted = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
        w_diff    = w_shifted - {1'b0, i_operand};

        if (i_div) begin
            // Remainder stays below the divisor, so the shifted value fits in
            // XLEN+1 bits and a negative trial result always sets the MSB.
            if (w_diff[XLEN]) begin
                o_acc = {w_shifted[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end else begin
                o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            end
        end else begin
            // Carry joins the top of the accumulator as the whole thing shifts right
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv_mdu.sv
`default_nettype none
// ============================================================================
// Module      : rv_mdu
// Description : Iterative RV32M multiply/divide unit. Operands are converted
//               to magnitudes on accept, iterated BITS_PER_CYCLE steps per
//               clock for XLEN/BITS_PER_CYCLE clocks, then sign-corrected into
//               the result register. Divide-by-zero and signed overflow bypass
//               the iteration and complete one clock after accept.
// Ports       : i_clk    - clock, rising edge
//               i_reset  - asynchronous reset, active low
//               i_valid  - operation request
//               o_ready  - request can be accepted this cycle (IDLE or DONE)
//               i_op     - funct3 of the M-extension instruction
//               i_rs1    - operand A (multiplicand / dividend)
//               i_rs2    - operand B (multiplier / divisor)
//               i_kill   - abort the current operation, no result produced
//               o_valid  - one-cycle completion pulse
//               o_result - result, held until the next completion
//               o_busy   - iteration in progress
// Revision    : 1.0 - initial release
// ============================================================================
module rv_mdu
    import rv_mdu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic             i_kill,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_result,
    output logic             o_busy
);

    localparam int c_steps = XLEN / BITS_PER_CYCLE;
    localparam int c_cnt_w = $clog2(c_steps + 1);

    mdu_state_e          r_state;
    mdu_state_e          w_state_next;
    mdu_op_e             r_op;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_operand;
    logic                r_neg_q;     // quotient / product must be negated
    logic                r_neg_r;     // remainder must be negated
    logic [c_cnt_w-1:0]  r_cnt;
    logic [XLEN-1:0]     r_result;

    mdu_op_e             w_op;
    logic                w_accept;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_overflow;
    logic                w_special;
    logic [XLEN-1:0]     w_special_result;
    logic                w_last;
    logic                w_div_mode;
    logic [2*XLEN-1:0]   w_final;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fixed;

    assign o_ready  = (r_state == IDLE) || (r_state == DONE);
    assign o_busy   = (r_state == CALC);
    assign o_valid  = (r_state == DONE);
    assign o_result = r_result;

    assign w_op     = mdu_op_e'(i_op);
    assign w_accept = i_valid && o_ready && !i_kill;
    assign w_last   = (r_cnt == c_cnt_w'(1));

    // ------------------------------------------------------------------
    // Request decode: magnitudes, signs and the bypass cases
    // ------------------------------------------------------------------
    always_comb begin
        w_sign_a   = is_signed_a(w_op) & i_rs1[XLEN-1];
        w_sign_b   = is_signed_b(w_op) & i_rs2[XLEN-1];
        w_mag_a    = w_sign_a ? -i_rs1 : i_rs1;
        w_mag_b    = w_sign_b ? -i_rs2 : i_rs2;
        w_div_zero = is_div(w_op) && (i_rs2 == '0);
        w_overflow = is_div(w_op) && is_signed_a(w_op)
                  && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                  && (i_rs2 == '1);
        w_special  = w_div_zero || w_overflow;

        if (w_div_zero) begin
            w_special_result = is_rem(w_op) ? i_rs1 : '1;
        end else begin
            w_special_result = is_rem(w_op) ? '0 : i_rs1;
        end
    end

    // ------------------------------------------------------------------
    // Iteration chain: BITS_PER_CYCLE steps evaluated per clock
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_chain [0:BITS_PER_CYCLE];

    assign w_div_mode = is_div(r_op);
    assign w_chain[0] = r_acc;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        mdu_iter_step #(
            .XLEN      (XLEN)
        ) u_step (
            .i_div     (w_div_mode),
            .i_acc     (w_chain[g]),
            .i_operand (r_operand),
            .o_acc     (w_chain[g+1])
        );
    end

    // ------------------------------------------------------------------
    // Sign fix-up of the final iteration output, registered on DONE entry
    // ------------------------------------------------------------------
    always_comb begin
        w_final = w_chain[BITS_PER_CYCLE];
        w_prod  = r_neg_q ? -w_final : w_final;
        w_quo   = r_neg_q ? -w_final[XLEN-1:0] : w_final[XLEN-1:0];
        w_rem   = r_neg_r ? -w_final[2*XLEN-1:XLEN] : w_final[2*XLEN-1:XLEN];

        if (is_div(r_op)) begin
            w_fixed = is_rem(r_op) ? w_rem : w_quo;
        end else if (r_op == OP_MUL) begin
            w_fixed = w_prod[XLEN-1:0];
        end else begin
            w_fixed = w_prod[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_next = w_special ? DONE : CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        // A flush overrides everything, including a completing iteration
        if (i_kill) begin
            w_state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_op      <= OP_MUL;
            r_acc     <= '0;
            r_operand <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_op    <= w_op;
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            r_cnt   <= c_cnt_w'(c_steps);
            if (is_div(w_op)) begin
                r_acc     <= {{XLEN{1'b0}}, w_mag_a};
                r_operand <= w_mag_b;
            end else begin
                r_acc     <= {{XLEN{1'b0}}, w_mag_b};
                r_operand <= w_mag_a;
            end
            if (w_special) begin
                r_result <= w_special_result;
            end
        end else if ((r_state == CALC) && !i_kill) begin
            r_acc <= w_final;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (w_last) begin
                r_result <= w_fixed;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rv_mdu.md
# rv_mdu

Iterative multiply/divide unit that brings the RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) to the RV32I core. It sits beside the ALU in the execute path. The core's control unit raises `i_valid` on an M-type instruction and stalls the PC register until `o_valid`. Latency is set by the datapath width and the number of result bits resolved per cycle.

## Interface
- `XLEN`, default 32: operand/result width; must be even and ≥ 8.
- `BITS_PER_CYCLE`, default 1: iteration steps per clock; must divide `XLEN`. `N = XLEN/BITS_PER_CYCLE`.
- `i_clk` in 1: single clock, all state updates on rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_valid` in 1: operation request.
- `o_ready` out 1: unit can accept a request this cycle.
- `i_op` in 3: instruction funct3 (000 MUL … 111 REMU, RV32M encoding).
- `i_rs1` in XLEN: operand A (dividend / multiplicand).
- `i_rs2` in XLEN: operand B (divisor / multiplier).
- `i_kill` in 1: abort current operation (core flush).
- `o_valid` out 1: one-cycle pulse, `o_result` is valid.
- `o_result` out XLEN: result; holds its value until the next completion.
- `o_busy` out 1: operation in flight (state CALC).

## Operation
- FSM states: IDLE, CALC, DONE. Reset: IDLE, `o_valid`=0, `o_busy`=0, `o_result`=0, all internal registers 0.
- `o_ready` = (state==IDLE) || (state==DONE). Accept = `i_valid && o_ready && !i_kill`.
- On accept, the unit latches the op. It also latches the operand magnitudes and the result sign:
  - DIV/REM/MULH: both operands are signed.
  - MULHSU: rs1 is signed and rs2 is unsigned.
  - MULHU/DIVU/REMU: both operands are unsigned.
  - MUL: only the low half is used, so it is treated as unsigned.
- Multiply path:
  - Shift-add on magnitudes into a 2·XLEN accumulator, `BITS_PER_CYCLE` multiplier bits per cycle.
  - In DONE the product is negated if the sign flag is set.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide path:
  - Restoring division on magnitudes, `BITS_PER_CYCLE` quotient bits per cycle.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Special cases are detected at accept and skip CALC (state goes directly to DONE):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1 = −2^(XLEN−1), rs2 = −1): DIV → rs1; REM → 0.
- CALC runs exactly `N` cycles, counted by a down-counter of width clog2(N+1). When the count is exhausted the state moves to DONE.
- DONE:
  - `o_valid`=1 for exactly this cycle and `o_result` is updated.
  - Next state is CALC on a new accept, otherwise IDLE. Back-to-back issue is supported.
- `i_kill`:
  - In any state, the next state is IDLE and no `o_valid` is produced.
  - `i_kill` has priority over a simultaneous `i_valid`.
  - `o_result` keeps its previous value.
- `i_valid` while in CALC is ignored, because `o_ready`=0.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous).

## Timing
- Normal op accepted at edge k: CALC occupies cycles k..k+N−1, DONE is entered at edge k+N, and `o_valid` is high in the cycle after edge k+N.
  - XLEN=32, BITS_PER_CYCLE=1 → 32 cycles.
  - BITS_PER_CYCLE=4 → 8 cycles.
- Special case accepted at edge k: `o_valid` is high in the cycle after edge k (latency 1).
- `o_result` is registered; there is no combinational path from inputs to `o_result` or `o_valid`.
- `o_ready` depends on state only.
- `i_kill` takes effect at the next edge.

## Structure
- Package `rv_mdu_pkg` holds:
  - `mdu_op_e`, the funct3 encodings for MUL…REMU.
  - `mdu_state_e`, with values IDLE/CALC/DONE.
  - The `is_div`, `is_signed_a` and `is_signed_b` decode functions.
- Sub-module `mdu_iter_step`: one combinational step, either a one-bit shift-add or a restoring subtract, selected by mode. It is instantiated `BITS_PER_CYCLE` times in a generate chain.
- Top-level `rv_mdu` contains the FSM, the counter, the sign fix-up and the result register.

## Test plan
- MUL 7×−3, XLEN=32, BITS_PER_CYCLE=1 → `o_result`=0xFFFFFFEB, with `o_valid` exactly 32 cycles after accept.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV −7/2 → 0xFFFFFFFD (−3).
  - REM −7/2 → 0xFFFFFFFF (−1).
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases, each with latency 1:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- Pulse `i_kill` at cycle 10 of a DIVU → no `o_valid`, `o_ready`=1 next cycle, `o_result` unchanged. Issue a new request in the DONE cycle → accepted, and its result arrives N cycles later.
- Assert `i_reset` low mid-CALC → `o_busy`/`o_valid`/`o_result` are 0 immediately. After release, rerun the signed and unsigned divide cases (−7/2, 100/7) with BITS_PER_CYCLE=4 → 8-cycle latency and results unchanged.
